// File: rtl/lcd_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_scanout: 640x480@60 VGA scanout of an RGB332 framebuffer to 24-bit RGB. |
// | Optional test pattern generator: define LCD_SCANOUT_TESTPAT_EN.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module lcd_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_pix,
`ifdef LCD_SCANOUT_TESTPAT_EN
  input  logic        testpat,
`endif
  output logic [18:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic        de,
  output logic        frame_start
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_hw      = $clog2(c_h_total);
  localparam int c_vw      = $clog2(c_v_total);

  localparam logic [c_hw-1:0] c_h_last = c_hw'(c_h_total - 1);
  localparam logic [c_hw-1:0] c_h_act  = c_hw'(H_ACTIVE);
  localparam logic [c_hw-1:0] c_hs_beg = c_hw'(H_ACTIVE + H_FP);
  localparam logic [c_hw-1:0] c_hs_end = c_hw'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [c_vw-1:0] c_v_last = c_vw'(c_v_total - 1);
  localparam logic [c_vw-1:0] c_v_act  = c_vw'(V_ACTIVE);
  localparam logic [c_vw-1:0] c_vs_beg = c_vw'(V_ACTIVE + V_FP);
  localparam logic [c_vw-1:0] c_vs_end = c_vw'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [18:0]     c_lin_last = 19'(H_ACTIVE * V_ACTIVE - 1);

  // Timing flag vector: {hsync, vsync, hblank, vblank, de, first_pixel}
  localparam int c_f_hs    = 5;
  localparam int c_f_vs    = 4;
  localparam int c_f_hb    = 3;
  localparam int c_f_vb    = 2;
  localparam int c_f_de    = 1;
  localparam int c_f_first = 0;
  localparam logic [5:0] c_flags_idle = 6'b111100;

  logic [c_hw-1:0] r_hcnt;
  logic [c_vw-1:0] r_vcnt;
  logic [18:0]     r_lin;
  logic [5:0]      r_flags0;
  logic [5:0]      r_flags1;
  logic [7:0]      r_pix;

  logic            w_h_act;
  logic            w_v_act;
  logic            w_active;
  logic            w_line_end;
  logic            w_frame_end;
  logic            w_fetch;
  logic [5:0]      w_flags;
  logic [7:0]      w_pix;

  assign w_h_act     = (r_hcnt < c_h_act);
  assign w_v_act     = (r_vcnt < c_v_act);
  assign w_active    = w_h_act & w_v_act;
  assign w_line_end  = (r_hcnt == c_h_last);
  assign w_frame_end = w_line_end & (r_vcnt == c_v_last);

  assign w_flags[c_f_hs]    = ~((r_hcnt >= c_hs_beg) && (r_hcnt < c_hs_end));
  assign w_flags[c_f_vs]    = ~((r_vcnt >= c_vs_beg) && (r_vcnt < c_vs_end));
  assign w_flags[c_f_hb]    = ~w_h_act;
  assign w_flags[c_f_vb]    = ~w_v_act;
  assign w_flags[c_f_de]    = w_active;
  assign w_flags[c_f_first] = (r_hcnt == '0) && (r_vcnt == '0);

`ifdef LCD_SCANOUT_TESTPAT_EN
  logic [7:0] r_tp_pix;
  logic [2:0] w_tp_hmid;
  logic [1:0] w_tp_hhi;
  logic [2:0] w_tp_vmid;

  assign w_tp_hmid = 3'(r_hcnt >> 3);
  assign w_tp_hhi  = 2'(r_hcnt >> 6);
  assign w_tp_vmid = 3'(r_vcnt >> 3);
  assign w_fetch   = w_active & ~testpat;
  assign w_pix     = testpat ? r_tp_pix : vram_data;

  // Grid colour travels with its stage-0 coordinates so it lands on the same pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tp_pix <= '0;
    end else if (ce_pix) begin
      r_tp_pix <= {w_tp_hmid, w_tp_vmid, w_tp_hhi};
    end
  end
`else
  assign w_fetch = w_active;
  assign w_pix   = vram_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (ce_pix) begin
      if (w_line_end) begin
        r_hcnt <= '0;
        r_vcnt <= w_frame_end ? '0 : r_vcnt + c_vw'(1);
      end else begin
        r_hcnt <= r_hcnt + c_hw'(1);
      end
    end
  end

  // Stage 0: issue the fetch; lin replaces y*H_ACTIVE+x and saturates defensively.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lin     <= '0;
      vram_addr <= '0;
      vram_rd   <= 1'b0;
      r_flags0  <= c_flags_idle;
    end else if (ce_pix) begin
      r_flags0 <= w_flags;
      vram_rd  <= w_fetch;
      if (w_active) begin
        vram_addr <= r_lin;
        r_lin     <= (r_lin == c_lin_last) ? r_lin : r_lin + 19'd1;
      end else if (w_frame_end) begin
        r_lin <= '0;
      end
    end
  end

  // Stage 1: capture the pixel returned for the stage-0 address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix    <= '0;
      r_flags1 <= c_flags_idle;
    end else if (ce_pix) begin
      r_pix    <= w_pix;
      r_flags1 <= r_flags0;
    end
  end

  // Stage 2: expand RGB332 by bit replication and blank outside the active area.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r      <= '0;
      g      <= '0;
      b      <= '0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      hblank <= 1'b1;
      vblank <= 1'b1;
      de     <= 1'b0;
    end else if (ce_pix) begin
      r      <= r_flags1[c_f_de] ? {r_pix[7:5], r_pix[7:5], r_pix[7:6]} : 8'h00;
      g      <= r_flags1[c_f_de] ? {r_pix[4:2], r_pix[4:2], r_pix[4:3]} : 8'h00;
      b      <= r_flags1[c_f_de] ? {r_pix[1:0], r_pix[1:0], r_pix[1:0], r_pix[1:0]} : 8'h00;
      hsync  <= r_flags1[c_f_hs];
      vsync  <= r_flags1[c_f_vs];
      hblank <= r_flags1[c_f_hb];
      vblank <= r_flags1[c_f_vb];
      de     <= r_flags1[c_f_de];
    end
  end

  // Pulse lasts one clk even when ce_pix is sparse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= ce_pix & r_flags1[c_f_first];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_scanout.sv
`default_nettype none
// Bench for lcd_scanout: full-size DUT for line timing plus a shrunken-geometry DUT
// for whole frames, both checked every clk against a position-based model.
module tb_lcd_scanout;

  typedef struct packed {
    int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb;
  } geom_t;

  localparam geom_t GD = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam geom_t GS = '{16, 2, 4, 3, 6, 1, 2, 2};
  localparam int    S_LAST = 95;
  localparam logic [49:0] RST_VEC = {19'd0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  logic clk;
  logic rst_n;
  logic ce_pix;
  logic tp;
  bit   ram_ff;
  int   spacing;
  int   ph;

  logic [18:0] d_addr, s_addr;
  logic        d_rd, s_rd;
  logic [7:0]  d_data, s_data;
  logic [7:0]  d_r, d_g, d_b, s_r, s_g, s_b;
  logic        d_hs, d_vs, d_hb, d_vb, d_de, d_fs;
  logic        s_hs, s_vs, s_hb, s_vb, s_de, s_fs;

  int   t;
  logic last_tick;
  int   n_chk, n_fail;

  lcd_scanout u_dut_d (
    .clk(clk), .rst_n(rst_n), .ce_pix(ce_pix),
`ifdef LCD_SCANOUT_TESTPAT_EN
    .testpat(tp),
`endif
    .vram_addr(d_addr), .vram_rd(d_rd), .vram_data(d_data),
    .r(d_r), .g(d_g), .b(d_b), .hsync(d_hs), .vsync(d_vs),
    .hblank(d_hb), .vblank(d_vb), .de(d_de), .frame_start(d_fs)
  );

  lcd_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_dut_s (
    .clk(clk), .rst_n(rst_n), .ce_pix(ce_pix),
`ifdef LCD_SCANOUT_TESTPAT_EN
    .testpat(tp),
`endif
    .vram_addr(s_addr), .vram_rd(s_rd), .vram_data(s_data),
    .r(s_r), .g(s_g), .b(s_b), .hsync(s_hs), .vsync(s_vs),
    .hblank(s_hb), .vblank(s_vb), .de(s_de), .frame_start(s_fs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clk-latency RAM: contents are the low address byte, or all ones.
  always @(posedge clk) begin
    d_data <= ram_ff ? 8'hFF : d_addr[7:0];
    s_data <= ram_ff ? 8'hFF : s_addr[7:0];
  end

  initial begin
    ce_pix = 1'b0;
    ph = 0;
    forever begin
      @(negedge clk);
      ph = (ph + 1 >= spacing) ? 0 : ph + 1;
      ce_pix = (ph == 0);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t         <= 0;
      last_tick <= 1'b0;
    end else begin
      t         <= ce_pix ? t + 1 : t;
      last_tick <= ce_pix;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %h, required %h", name, t, got, exp);
    end
  endtask

  function automatic int fetch_addr(input geom_t gm, input int x, input int y);
    if (x < gm.ha && y < gm.va) return y * gm.ha + x;
    if (y < gm.va) return y * gm.ha + gm.ha - 1;
    return gm.ha * gm.va - 1;
  endfunction

  // After t pixel ticks the fetch stage holds position t-1 and the outputs show t-3.
  function automatic logic [49:0] model(input geom_t gm, input int tk, input logic tick, input logic tpm);
    int ht, vt, j, x, y;
    logic [18:0] a;
    logic rd, hs, vs, hb, vb, dv, fs;
    logic [7:0] p, rr, gg, bb, xb, yb;
    ht = gm.ha + gm.hf + gm.hs + gm.hb;
    vt = gm.va + gm.vf + gm.vs + gm.vb;
    a = '0; rd = 1'b0; rr = '0; gg = '0; bb = '0;
    hs = 1'b1; vs = 1'b1; hb = 1'b1; vb = 1'b1; dv = 1'b0; fs = 1'b0;
    if (tk >= 1) begin
      j = (tk - 1) % (ht * vt);
      x = j % ht;
      y = j / ht;
      rd = (x < gm.ha) && (y < gm.va) && !tpm;
      a = 19'(fetch_addr(gm, x, y));
    end
    if (tk >= 3) begin
      j = (tk - 3) % (ht * vt);
      x = j % ht;
      y = j / ht;
      hb = (x >= gm.ha);
      vb = (y >= gm.va);
      dv = !hb && !vb;
      hs = !((x >= gm.ha + gm.hf) && (x < gm.ha + gm.hf + gm.hs));
      vs = !((y >= gm.va + gm.vf) && (y < gm.va + gm.vf + gm.vs));
      fs = tick && dv && (x == 0) && (y == 0);
      if (dv) begin
        xb = 8'(x);
        yb = 8'(y);
        p  = tpm ? {xb[5:3], yb[5:3], xb[7:6]} : (ram_ff ? 8'hFF : 8'(y * gm.ha + x));
        rr = {p[7:5], p[7:5], p[7:6]};
        gg = {p[4:2], p[4:2], p[4:3]};
        bb = {p[1:0], p[1:0], p[1:0], p[1:0]};
      end
    end
    return {a, rd, rr, gg, bb, hs, vs, hb, vb, dv, fs};
  endfunction

  bit   mon_en;
  logic p_d_de, p_d_hs, p_s_vs;
  int   d_de_rise, d_hr, s_vf, s_vr, n_hf, fs_cnt, n95, rd_cnt, s_prev;
  int   d_hf [2];

  always @(negedge clk) begin
    check("default_dut", 64'({d_addr, d_rd, d_r, d_g, d_b, d_hs, d_vs, d_hb, d_vb, d_de, d_fs}),
          64'(model(GD, t, last_tick, tp)));
    check("small_dut", 64'({s_addr, s_rd, s_r, s_g, s_b, s_hs, s_vs, s_hb, s_vb, s_de, s_fs}),
          64'(model(GS, t, last_tick, tp)));
    if (last_tick) begin
      if (mon_en) begin
        if (d_de && !p_d_de && d_de_rise < 0) d_de_rise = t;
        if (!d_hs && p_d_hs) begin
          if (n_hf < 2) d_hf[n_hf] = t;
          n_hf++;
        end
        if (d_hs && !p_d_hs && d_hr < 0) d_hr = t;
        if (!s_vs && p_s_vs && s_vf < 0) s_vf = t;
        if (s_vs && !p_s_vs && s_vr < 0) s_vr = t;
      end
      p_d_de = d_de;
      p_d_hs = d_hs;
      p_s_vs = s_vs;
      if (s_rd) begin
        check("small_addr_seq", 64'(s_addr), 64'((s_prev == S_LAST) ? 0 : s_prev + 1));
        if (s_addr == 19'(S_LAST)) n95++;
        s_prev = int'(s_addr);
      end
    end
    if (mon_en && s_fs && t <= 825) fs_cnt++;
    if (tp && (d_rd || s_rd)) rd_cnt++;
    if (!rst_n) s_prev = S_LAST;
  end

  task automatic wait_ticks(input int target);
    int guard;
    guard = 0;
    while (t < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (t < target) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_ticks: t=%0d, required %0d", t, target);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; tp = 1'b0; ram_ff = 1'b0; spacing = 4; mon_en = 1'b1;
    p_d_de = 1'b0; p_d_hs = 1'b1; p_s_vs = 1'b1;
    d_de_rise = -1; d_hr = -1; s_vf = -1; s_vr = -1; n_hf = 0; fs_cnt = 0;
    n95 = 0; rd_cnt = 0; s_prev = S_LAST;
    d_hf[0] = -1; d_hf[1] = -1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Byte 0x05 at x=5 leaves the output stage after tick 8.
    wait_ticks(8);
    check("pixel_x5_rgb_de", 64'({d_r, d_g, d_b, d_de}), 64'({8'h00, 8'h24, 8'h55, 1'b1}));

    wait_ticks(1900);
    check("hsync_start_after_de", 64'(d_hf[0] - d_de_rise), 64'(656));
    check("hsync_width", 64'(d_hr - d_hf[0]), 64'(96));
    check("line_length", 64'(d_hf[1] - d_hf[0]), 64'(800));
    check("small_vsync_start", 64'(s_vf), 64'(178));
    check("small_vsync_width", 64'(s_vr - s_vf), 64'(50));
    check("frame_start_3_frames", 64'(fs_cnt), 64'(3));

    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_default_async", 64'({d_addr, d_rd, d_r, d_g, d_b, d_hs, d_vs, d_hb, d_vb, d_de, d_fs}), 64'(RST_VEC));
    check("reset_small_async", 64'({s_addr, s_rd, s_r, s_g, s_b, s_hs, s_vs, s_hb, s_vb, s_de, s_fs}), 64'(RST_VEC));

    repeat (2) @(negedge clk);
    ram_ff = 1'b1;
    spacing = 2;
    n95 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(1);
    check("first_addr_after_reset", 64'({d_addr, d_rd}), 64'({19'd0, 1'b1}));
    wait_ticks(3);
    check("small_ff_white", 64'({s_r, s_g, s_b, s_de}), 64'({24'hFFFFFF, 1'b1}));
    wait_ticks(700);
    check("small_last_addr_count", 64'(n95), 64'(3));

`ifdef LCD_SCANOUT_TESTPAT_EN
    rst_n = 1'b0;
    tp = 1'b1;
    ram_ff = 1'b0;
    rd_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(11);
    check("testpat_pixel_8_0", 64'({d_r, d_g, d_b}), 64'(24'h240000));
    wait_ticks(300);
    check("testpat_no_reads", 64'(rd_cnt), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
